w5500_frame_ctrl: RTL and testbench

//  Sequences the 8-bit SPI master into complete W5500 VDM frames (16-bit addr, control byte, N data bytes).

---
 rtl/w5500_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_w5500_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w5500_frame_ctrl.sv
// W5500 VDM frame sequencer: wraps address, control and data bytes into one
// chip-select window on top of an 8-bit SPI master.
module w5500_frame_ctrl #(
  parameter int LEN_W    = 11,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [4:0]       cmd_bsb,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             wdat_req,
  input  logic [7:0]       wdat,
  output logic [7:0]       rdat,
  output logic             rdat_vld,
  output logic             done,
  output logic             err,
  output logic             spi_wr,
  output logic [1:0]       spi_wr_len,
  output logic [31:0]      spi_wrdata,
  input  logic [31:0]      spi_rddata,
  input  logic             spi_wr_done,
  input  logic             spi_ready,
  output logic             cs_n
);

  localparam int CW = 8;
  localparam int TW = $clog2(TIMEOUT) + 1;

  // ADDR/CTRL/DATA share one ISSUE/WAIT pair; phase selects the word built.
  typedef enum logic [2:0] {
    S_IDLE, S_CS_SU, S_ISSUE, S_WAIT, S_WREQ, S_LATCH, S_CS_HD, S_GAP
  } state_t;

  typedef enum logic [1:0] {PH_ADDR, PH_CTRL, PH_DATA} phase_t;

  state_t           state, state_d;
  phase_t           phase, phase_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [TW-1:0]    tmo, tmo_d;
  logic [LEN_W-1:0] left, left_d;
  logic             rw_q, rw_d;
  logic [4:0]       bsb_q, bsb_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wbyte, wbyte_d;
  logic             aborted, aborted_d;
  logic             try_issue;

  logic             cmd_ready_d, wdat_req_d, rdat_vld_d, done_d, err_d, spi_wr_d, cs_n_d;
  logic [7:0]       rdat_d;
  logic [1:0]       spi_wr_len_d;
  logic [31:0]      spi_wrdata_d;

  logic             unused_rddata;
  assign unused_rddata = ^spi_rddata[31:8];

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    cnt_d        = cnt;
    tmo_d        = tmo;
    left_d       = left;
    rw_d         = rw_q;
    bsb_d        = bsb_q;
    addr_d       = addr_q;
    wbyte_d      = wbyte;
    aborted_d    = aborted;
    rdat_d       = rdat;
    spi_wr_len_d = spi_wr_len;
    spi_wrdata_d = spi_wrdata;
    cs_n_d       = cs_n;
    wdat_req_d   = 1'b0;
    rdat_vld_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    spi_wr_d     = 1'b0;
    try_issue    = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rw_d    = cmd_rw;
          bsb_d   = cmd_bsb;
          addr_d  = cmd_addr;
          left_d  = cmd_len;
          cnt_d   = '0;
          phase_d = PH_ADDR;
          if (cmd_len == '0) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_GAP;
          end else begin
            cs_n_d  = 1'b0;
            state_d = S_CS_SU;
          end
        end
      end
      S_CS_SU: begin
        if (cnt == CW'(CS_SETUP - 1)) begin
          state_d   = S_ISSUE;
          try_issue = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_ISSUE: try_issue = 1'b1;
      S_WAIT: begin
        if (spi_wr_done) begin
          case (phase)
            PH_ADDR: begin
              phase_d = PH_CTRL;
              state_d = S_ISSUE;
            end
            PH_CTRL: begin
              phase_d = PH_DATA;
              if (rw_q) begin
                wdat_req_d = 1'b1;
                state_d    = S_WREQ;
              end else begin
                state_d = S_ISSUE;
              end
            end
            default: begin
              left_d = left - LEN_W'(1);
              if (!rw_q) begin
                rdat_d     = spi_rddata[7:0];
                rdat_vld_d = 1'b1;
              end
              if (left == LEN_W'(1)) begin
                cnt_d   = '0;
                state_d = S_CS_HD;
              end else if (rw_q) begin
                wdat_req_d = 1'b1;
                state_d    = S_WREQ;
              end else begin
                state_d = S_ISSUE;
              end
            end
          endcase
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          aborted_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_CS_HD;
        end else begin
          tmo_d = tmo + TW'(1);
        end
      end
      S_WREQ:  state_d = S_LATCH;
      S_LATCH: begin
        wbyte_d = wdat;
        state_d = S_ISSUE;
      end
      S_CS_HD: begin
        if (cnt == CW'(CS_HOLD - 1)) begin
          cs_n_d    = 1'b1;
          done_d    = !aborted;
          aborted_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == CW'(CS_IDLE - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (try_issue && spi_ready) begin
      spi_wr_d = 1'b1;
      tmo_d    = '0;
      state_d  = S_WAIT;
      case (phase)
        PH_ADDR: begin
          spi_wrdata_d = {addr_q, 16'h0000};
          spi_wr_len_d = 2'd1;
        end
        PH_CTRL: begin
          spi_wrdata_d = {bsb_q, rw_q, 2'b00, 24'h000000};
          spi_wr_len_d = 2'd0;
        end
        default: begin
          spi_wrdata_d = rw_q ? {wbyte, 24'h000000} : '0;
          spi_wr_len_d = 2'd0;
        end
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      phase      <= PH_ADDR;
      cnt        <= '0;
      tmo        <= '0;
      left       <= '0;
      rw_q       <= 1'b0;
      bsb_q      <= '0;
      addr_q     <= '0;
      wbyte      <= '0;
      aborted    <= 1'b0;
      cmd_ready  <= 1'b0;
      wdat_req   <= 1'b0;
      rdat       <= '0;
      rdat_vld   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      spi_wr     <= 1'b0;
      spi_wr_len <= '0;
      spi_wrdata <= '0;
      cs_n       <= 1'b1;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      tmo        <= tmo_d;
      left       <= left_d;
      rw_q       <= rw_d;
      bsb_q      <= bsb_d;
      addr_q     <= addr_d;
      wbyte      <= wbyte_d;
      aborted    <= aborted_d;
      cmd_ready  <= cmd_ready_d;
      wdat_req   <= wdat_req_d;
      rdat       <= rdat_d;
      rdat_vld   <= rdat_vld_d;
      done       <= done_d;
      err        <= err_d;
      spi_wr     <= spi_wr_d;
      spi_wr_len <= spi_wr_len_d;
      spi_wrdata <= spi_wrdata_d;
      cs_n       <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_w5500_frame_ctrl.sv
// Scoreboard bench for w5500_frame_ctrl with a small SPI master model and
// a write-byte source.
module tb_w5500_frame_ctrl;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int TIMEOUT  = 4096;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [4:0]  cmd_bsb;
  logic [15:0] cmd_addr;
  logic [10:0] cmd_len;
  logic        wdat_req;
  logic [7:0]  wdat, rdat;
  logic        rdat_vld, done, err, spi_wr;
  logic [1:0]  spi_wr_len;
  logic [31:0] spi_wrdata, spi_rddata;
  logic        spi_wr_done, spi_ready, cs_n;

  w5500_frame_ctrl #(
    .LEN_W(11), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_bsb(cmd_bsb), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdat_req(wdat_req),
    .wdat(wdat), .rdat(rdat), .rdat_vld(rdat_vld), .done(done), .err(err),
    .spi_wr(spi_wr), .spi_wr_len(spi_wr_len), .spi_wrdata(spi_wrdata),
    .spi_rddata(spi_rddata), .spi_wr_done(spi_wr_done), .spi_ready(spi_ready), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0, fails = 0;
  logic [33:0] exp_word_q[$];
  logic [7:0]  exp_rdat_q[$];
  logic        exp_err_q[$];
  logic [7:0]  wdat_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI master model: completes each transfer 3 cycles after spi_wr
  bit        withhold = 0;
  logic [7:0] rd_val = 8'h00;
  bit        busy = 0;
  int        dly = 0;
  int        model_done_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      busy = 0; spi_wr_done = 1'b0; spi_ready = 1'b1; spi_rddata = 32'hDEADBEEF;
    end else begin
      spi_wr_done = 1'b0;
      spi_rddata  = 32'hDEADBEEF;
      if (busy && !withhold) begin
        if (dly == 0) begin
          spi_wr_done = 1'b1; spi_rddata = {24'h5A5A5A, rd_val};
          busy = 0; spi_ready = 1'b1; model_done_cyc = cyc;
        end else dly--;
      end
      if (spi_wr) begin
        check("spi_wr_while_busy", {63'd0, busy}, 64'd0);
        busy = 1; spi_ready = 1'b0; dly = 2;
      end
    end
  end

  // Write-byte source: serves one byte per wdat_req
  int wreq_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      wdat = 8'h00; wdat_q.delete();
    end else if (wdat_req) begin
      wreq_cnt++;
      wdat = (wdat_q.size() > 0) ? wdat_q.pop_front() : 8'hEE;
    end
  end

  // Monitor
  int nwr = 0, ndone = 0, nfall = 0;
  int last_issue = 0, first_wr = 0, done_cyc = 0, cs_rise = 0, cs_fall = 0, last_gap = 0;
  bit first_pending = 0;
  logic cs_prev = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      exp_word_q.delete(); exp_rdat_q.delete(); exp_err_q.delete();
      cs_prev = 1'b1; first_pending = 0;
    end else begin
      if (spi_wr) begin
        nwr++; last_issue = cyc;
        if (first_pending) begin first_wr = cyc; first_pending = 0; end
        check("cs_low_at_wr", {63'd0, cs_n}, 64'd0);
        if (exp_word_q.size() == 0) check("unexpected_spi_wr", 64'd1, 64'd0);
        else check("spi_word", {30'd0, spi_wr_len, spi_wrdata}, {30'd0, exp_word_q.pop_front()});
      end
      if (rdat_vld) begin
        if (exp_rdat_q.size() == 0) check("unexpected_rdat_vld", 64'd1, 64'd0);
        else check("rdat", {56'd0, rdat}, {56'd0, exp_rdat_q.pop_front()});
      end
      if (done) begin
        ndone++; done_cyc = cyc;
        if (exp_err_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("done_err", {63'd0, err}, {63'd0, exp_err_q.pop_front()});
      end else if (err) check("err_without_done", 64'd1, 64'd0);
      if (cs_n && !cs_prev) cs_rise = cyc;
      if (!cs_n && cs_prev) begin
        cs_fall = cyc; nfall++; last_gap = cyc - cs_rise; first_pending = 1;
      end
      cs_prev = cs_n;
    end
  end

  task automatic send_cmd(input logic rw, input logic [4:0] bsb, input logic [15:0] addr,
                          input logic [10:0] len, input bit keep);
    int n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_bsb = bsb; cmd_addr = addr; cmd_len = len;
    while (!cmd_ready && n < 3000) begin @(negedge clk); #1; n++; end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    if (!keep) begin
      cmd_valid = 1'b0; cmd_rw = ~rw; cmd_bsb = 5'h1F; cmd_addr = 16'hFFFF; cmd_len = '1;
    end
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while (ndone < target && n < bound) begin @(negedge clk); #1; n++; end
    check("done_seen", {63'd0, ndone >= target}, 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic push_frame(input logic rw, input logic [4:0] bsb, input logic [15:0] addr,
                            input int len, input logic [7:0] b[6]);
    exp_word_q.push_back({2'd1, addr, 16'h0000});
    exp_word_q.push_back({2'd0, bsb, rw, 2'b00, 24'h000000});
    for (int i = 0; i < len; i++) begin
      if (rw) begin
        wdat_q.push_back(b[i]);
        exp_word_q.push_back({2'd0, b[i], 24'h000000});
      end else begin
        exp_word_q.push_back(34'd0);
        exp_rdat_q.push_back(rd_val);
      end
    end
    exp_err_q.push_back(1'b0);
  endtask

  int base_done, base_wreq, base_wr, base_fall;
  logic [7:0] bytes[6];

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_bsb = '0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", {63'd0, cs_n}, 64'd1);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_strobes", {58'd0, spi_wr, wdat_req, rdat_vld, done, err, 1'b0}, 64'd0);
    check("rst_spi_word", {30'd0, spi_wr_len, spi_wrdata}, 64'd0);
    check("rst_rdat", {56'd0, rdat}, 64'd0);
    rst = 1'b1;
    check("cmd_ready_at_release", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk); #1;
    check("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);

    // Write frame
    bytes = '{8'hC0, 8'hA8, 8'h01, 8'h64, 8'h00, 8'h00};
    base_done = ndone; base_wreq = wreq_cnt; base_fall = nfall;
    push_frame(1'b1, 5'h01, 16'h0001, 4, bytes);
    send_cmd(1'b1, 5'h01, 16'h0001, 11'd4, 0);
    wait_done(base_done + 1, 2000);
    check("write_wdat_req_count", 64'(wreq_cnt - base_wreq), 64'd4);
    check("write_single_cs_window", 64'(nfall - base_fall), 64'd1);
    check("cs_setup", 64'(first_wr - cs_fall), 64'(CS_SETUP));
    check("cs_hold", 64'(cs_rise - model_done_cyc), 64'(CS_HOLD + 1));
    check("cs_rise_with_done", 64'(cs_rise), 64'(done_cyc));

    // Read frame
    rd_val = 8'h04;
    bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    base_done = ndone;
    push_frame(1'b0, 5'h00, 16'h0039, 1, bytes);
    send_cmd(1'b0, 5'h00, 16'h0039, 11'd1, 0);
    wait_done(base_done + 1, 2000);
    check("read_queues_drained", 64'(exp_word_q.size() + exp_rdat_q.size()), 64'd0);

    // Zero-length command
    base_wr = nwr; base_fall = nfall; base_done = ndone;
    exp_err_q.push_back(1'b1);
    send_cmd(1'b1, 5'h02, 16'h1234, 11'd0, 0);
    check("len0_done_err", {62'd0, done, err}, 64'd3);
    repeat (10) @(negedge clk);
    #1;
    check("len0_no_spi_wr", 64'(nwr - base_wr), 64'd0);
    check("len0_cs_stays_high", {31'd0, 32'(nfall - base_fall), cs_n}, 64'd1);

    // Timeout: SPI master never completes the address transfer
    withhold = 1;
    base_done = ndone;
    exp_word_q.push_back({2'd1, 16'h0100, 16'h0000});
    exp_err_q.push_back(1'b1);
    send_cmd(1'b0, 5'h03, 16'h0100, 11'd2, 0);
    wait_done(base_done + 1, TIMEOUT + 200);
    check("timeout_latency", 64'(done_cyc - last_issue), 64'(TIMEOUT));
    repeat (CS_HOLD + 3) @(negedge clk);
    #1;
    check("timeout_cs_hold", 64'(cs_rise - done_cyc), 64'(CS_HOLD));
    check("timeout_single_done", 64'(ndone - base_done), 64'd1);
    withhold = 0;
    repeat (10) @(negedge clk);

    // Back-to-back commands with cmd_valid held high
    base_done = ndone; base_fall = nfall;
    rd_val = 8'h5C;
    bytes = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(1'b1, 5'h01, 16'h0010, 2, bytes);
    push_frame(1'b0, 5'h03, 16'h1234, 2, bytes);
    send_cmd(1'b1, 5'h01, 16'h0010, 11'd2, 1);
    send_cmd(1'b0, 5'h03, 16'h1234, 11'd2, 0);
    wait_done(base_done + 2, 3000);
    check("b2b_cs_windows", 64'(nfall - base_fall), 64'd2);
    check("b2b_cs_idle_gap", {63'd0, last_gap >= CS_IDLE}, 64'd1);

    // Reset during the third data byte
    base_wreq = wreq_cnt; base_wr = nwr;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    push_frame(1'b1, 5'h02, 16'h0200, 6, bytes);
    send_cmd(1'b1, 5'h02, 16'h0200, 11'd6, 0);
    for (int n = 0; n < 500 && (nwr - base_wr) < 5; n++) begin @(negedge clk); #1; end
    check("reached_third_byte", 64'(nwr - base_wr), 64'd5);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_cs_n", {63'd0, cs_n}, 64'd1);
    check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    base_done = ndone;
    rd_val = 8'hA5;
    push_frame(1'b0, 5'h01, 16'h0002, 1, bytes);
    send_cmd(1'b0, 5'h01, 16'h0002, 11'd1, 0);
    wait_done(base_done + 1, 2000);

    check("queues_empty",
          64'(exp_word_q.size() + exp_rdat_q.size() + exp_err_q.size() + wdat_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
